clint_timer: RTL and testbench

CLINT_TIMER -- requirements
Module: clint_timer

---
 rtl/clint_timer.sv | 233 +++++++++++++++++++++++
 tb/tb_clint_timer.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/clint_timer.sv
// clint_timer: RISC-V style core-local timer (mtime / mtimecmp / msip).
//
// Register window (word offsets, addr_i[1:0] ignored):
//   0x00 mtime[31:0]      (load also snapshots mtime[63:32] into a shadow)
//   0x04 mtime[63:32]     (load returns the shadow, not the live value)
//   0x08 mtimecmp[31:0]
//   0x0C mtimecmp[63:32]
//   0x10 msip             (bit 0 only, upper bits read 0)
//   0x14 prescale         (tick divider, only with CLINT_PRESCALE_EN)
//   0x18, 0x1C            reserved: read 0, stores ignored
//
// Optional feature macro: CLINT_PRESCALE_EN
//   defined   -> mtime advances once every prescale+1 clocks, prescale is
//                a read/write register reset to PRESCALE_RESET.
//   undefined -> mtime advances every clock, offset 0x14 reads 0 and
//                stores to it are ignored; no divider hardware is built.
//
// Access protocol: req_i marks a single-cycle access and is always accepted
// (there is no ready; one access per cycle, never stalled). A store
// (req_i && we_i) takes effect on the same rising edge. A load
// (req_i && !we_i) is answered with rdata_o and a one-cycle rvalid_o pulse
// on the following cycle; rdata_o holds its previous value otherwise.

module clint_timer #(
    parameter logic [31:0] PRESCALE_RESET = 32'd99,
    parameter logic [63:0] MTIMECMP_RESET = 64'hFFFF_FFFF_FFFF_FFFF
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_i,
    input  logic        we_i,
    input  logic [4:0]  addr_i,
    input  logic [31:0] wdata_i,
    output logic [31:0] rdata_o,
    output logic        rvalid_o,
    output logic        mtip_o,
    output logic        msip_o
);

    // Word index of each register inside the window (addr_i[4:2]).
    localparam logic [2:0] W_MTIME_LO = 3'd0;
    localparam logic [2:0] W_MTIME_HI = 3'd1;
    localparam logic [2:0] W_CMP_LO   = 3'd2;
    localparam logic [2:0] W_CMP_HI   = 3'd3;
    localparam logic [2:0] W_MSIP     = 3'd4;
    localparam logic [2:0] W_PRESCALE = 3'd5;

    // ------------------------------------------------------------------
    // Access decode
    // ------------------------------------------------------------------
    logic       wr_en;
    logic       rd_en;
    logic [2:0] word_sel;

    logic wr_mtime_lo;
    logic wr_mtime_hi;
    logic wr_cmp_lo;
    logic wr_cmp_hi;
    logic wr_msip;
    logic wr_prescale;

    // Byte lanes inside a word are not addressable; the low bits are dropped.
    logic unused_addr_bits;
    assign unused_addr_bits = ^addr_i[1:0];

    // Split the strobe into load/store and one-hot store selects.
    always_comb begin
        wr_en       = req_i & we_i;
        rd_en       = req_i & ~we_i;
        word_sel    = addr_i[4:2];
        wr_mtime_lo = wr_en && (word_sel == W_MTIME_LO);
        wr_mtime_hi = wr_en && (word_sel == W_MTIME_HI);
        wr_cmp_lo   = wr_en && (word_sel == W_CMP_LO);
        wr_cmp_hi   = wr_en && (word_sel == W_CMP_HI);
        wr_msip     = wr_en && (word_sel == W_MSIP);
        wr_prescale = wr_en && (word_sel == W_PRESCALE);
    end

    // ------------------------------------------------------------------
    // Tick generation
    // ------------------------------------------------------------------
    logic        tick;
    logic [31:0] prescale_rd;

`ifdef CLINT_PRESCALE_EN
    logic [31:0] prescale_q;
    logic [31:0] prescale_d;
    logic [31:0] pcnt_q;
    logic [31:0] pcnt_d;
    logic        unused_wr_prescale;

    assign unused_wr_prescale = 1'b0;

    // Divider: count 0..prescale, tick on the terminal count and wrap.
    // Rewriting prescale restarts the count so a new period starts cleanly.
    always_comb begin
        tick       = (pcnt_q == prescale_q);
        prescale_d = prescale_q;
        pcnt_d     = tick ? 32'd0 : (pcnt_q + 32'd1);
        if (wr_prescale) begin
            prescale_d = wdata_i;
            pcnt_d     = 32'd0;
        end
        prescale_rd = prescale_q;
    end

    // Divider state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prescale_q <= PRESCALE_RESET;
            pcnt_q     <= 32'd0;
        end else begin
            prescale_q <= prescale_d;
            pcnt_q     <= pcnt_d;
        end
    end
`else
    // Without the divider the reset value and the store select have no use.
    logic unused_prescale;
    assign unused_prescale = (^PRESCALE_RESET) ^ wr_prescale;

    // mtime advances on every clock; prescale reads as zero.
    always_comb begin
        tick        = 1'b1;
        prescale_rd = 32'd0;
    end
`endif

    // ------------------------------------------------------------------
    // mtime
    // ------------------------------------------------------------------
    logic [63:0] mtime_q;
    logic [63:0] mtime_d;

    // Software stores win over the tick; a tick on the same edge is lost.
    // The increment wraps naturally from all-ones to zero.
    always_comb begin
        mtime_d = mtime_q;
        if (wr_mtime_lo) begin
            mtime_d = {mtime_q[63:32], wdata_i};
        end else if (wr_mtime_hi) begin
            mtime_d = {wdata_i, mtime_q[31:0]};
        end else if (tick) begin
            mtime_d = mtime_q + 64'd1;
        end
    end

    // ------------------------------------------------------------------
    // mtimecmp and msip
    // ------------------------------------------------------------------
    logic [63:0] mtimecmp_q;
    logic [63:0] mtimecmp_d;
    logic        msip_q;
    logic        msip_d;

    // Half-word updates of the compare value and the software interrupt bit.
    always_comb begin
        mtimecmp_d = mtimecmp_q;
        msip_d     = msip_q;
        if (wr_cmp_lo) begin
            mtimecmp_d[31:0] = wdata_i;
        end
        if (wr_cmp_hi) begin
            mtimecmp_d[63:32] = wdata_i;
        end
        if (wr_msip) begin
            msip_d = wdata_i[0];
        end
    end

    // ------------------------------------------------------------------
    // Load path, hi-word shadow and timer interrupt
    // ------------------------------------------------------------------
    logic [31:0] rd_word;
    logic [31:0] rdata_q;
    logic [31:0] rdata_d;
    logic        rvalid_q;
    logic        rvalid_d;
    logic [31:0] shadow_q;
    logic [31:0] shadow_d;
    logic        mtip_q;
    logic        mtip_d;

    // Read mux. Loading mtime lo captures the matching hi word so software
    // reading lo then hi sees one consistent 64-bit sample even if lo
    // carries into hi between the two loads.
    always_comb begin
        rd_word = 32'd0;
        case (word_sel)
            W_MTIME_LO: rd_word = mtime_q[31:0];
            W_MTIME_HI: rd_word = shadow_q;
            W_CMP_LO:   rd_word = mtimecmp_q[31:0];
            W_CMP_HI:   rd_word = mtimecmp_q[63:32];
            W_MSIP:     rd_word = {31'd0, msip_q};
            W_PRESCALE: rd_word = prescale_rd;
            default:    rd_word = 32'd0;
        endcase

        rdata_d  = rd_en ? rd_word : rdata_q;
        rvalid_d = rd_en;
        shadow_d = (rd_en && (word_sel == W_MTIME_LO)) ? mtime_q[63:32] : shadow_q;

        // Unsigned 64-bit compare, registered: one cycle behind mtime/mtimecmp.
        mtip_d = (mtime_q >= mtimecmp_q);
    end

    // All timer, register and response state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mtime_q    <= 64'd0;
            mtimecmp_q <= MTIMECMP_RESET;
            msip_q     <= 1'b0;
            shadow_q   <= 32'd0;
            rdata_q    <= 32'd0;
            rvalid_q   <= 1'b0;
            mtip_q     <= 1'b0;
        end else begin
            mtime_q    <= mtime_d;
            mtimecmp_q <= mtimecmp_d;
            msip_q     <= msip_d;
            shadow_q   <= shadow_d;
            rdata_q    <= rdata_d;
            rvalid_q   <= rvalid_d;
            mtip_q     <= mtip_d;
        end
    end

    assign rdata_o  = rdata_q;
    assign rvalid_o = rvalid_q;
    assign mtip_o   = mtip_q;
    assign msip_o   = msip_q;

endmodule

// File: tb/tb_clint_timer.sv
// tb_clint_timer: directed bench for clint_timer. Inputs change on the
// falling edge, outputs are sampled on the falling edge. Works with or
// without CLINT_PRESCALE_EN; in the divided build prescale is set to 0
// after its own test so later sequences see one tick per clock.

module tb_clint_timer;

    logic        clk;
    logic        rst_n;
    logic        req_i;
    logic        we_i;
    logic [4:0]  addr_i;
    logic [31:0] wdata_i;
    logic [31:0] rdata_o;
    logic        rvalid_o;
    logic        mtip_o;
    logic        msip_o;

    int checks;
    int failures;

`ifdef CLINT_PRESCALE_EN
    localparam logic [31:0] RST_PRESCALE_RB = 32'd99;
    localparam logic [31:0] NEW_PRESCALE_RB = 32'd7;
`else
    localparam logic [31:0] RST_PRESCALE_RB = 32'd0;
    localparam logic [31:0] NEW_PRESCALE_RB = 32'd0;
`endif

    typedef struct {
        string       name;
        logic        req;
        logic        we;
        logic [4:0]  addr;
        logic [31:0] wdata;
        logic [31:0] exp_rdata;
        logic        exp_msip;
    } vec_t;

    localparam int NVEC = 19;
    vec_t vecs[NVEC];

    clint_timer #(
        .PRESCALE_RESET(32'd99),
        .MTIMECMP_RESET(64'hFFFF_FFFF_FFFF_FFFF)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .req_i   (req_i),
        .we_i    (we_i),
        .addr_i  (addr_i),
        .wdata_i (wdata_i),
        .rdata_o (rdata_o),
        .rvalid_o(rvalid_o),
        .mtip_o  (mtip_o),
        .msip_o  (msip_o)
    );

    // Clock and watchdog.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    function automatic vec_t mk(input string n, input logic rq, input logic w,
                                input logic [4:0] a, input logic [31:0] d,
                                input logic [31:0] er, input logic em);
        vec_t v;
        v.name = n; v.req = rq; v.we = w; v.addr = a; v.wdata = d;
        v.exp_rdata = er; v.exp_msip = em;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic store(input logic [4:0] a, input logic [31:0] d);
        req_i   = 1'b1;
        we_i    = 1'b1;
        addr_i  = a;
        wdata_i = d;
        @(negedge clk);
        req_i = 1'b0;
        we_i  = 1'b0;
    endtask

    task automatic load(input string name, input logic [4:0] a, output logic [31:0] d);
        req_i  = 1'b1;
        we_i   = 1'b0;
        addr_i = a;
        @(negedge clk);
        req_i = 1'b0;
        check({name, "_rvalid"}, {31'd0, rvalid_o}, 32'd1);
        d = rdata_o;
    endtask

    task automatic load_check(input string name, input logic [4:0] a, input logic [31:0] exp);
        logic [31:0] d;
        load(name, a, d);
        check(name, d, exp);
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        logic [31:0] d;
        logic [31:0] last_rd;
        logic        exp_valid;

        checks   = 0;
        failures = 0;
        rst_n    = 1'b0;
        req_i    = 1'b0;
        we_i     = 1'b0;
        addr_i   = 5'd0;
        wdata_i  = 32'd0;

        vecs[0]  = mk("st_cmp_lo",    1, 1, 5'h08, 32'h1234_5678, 32'h0,          0);
        vecs[1]  = mk("ld_cmp_lo",    1, 0, 5'h08, 32'h0,         32'h1234_5678,  0);
        vecs[2]  = mk("st_cmp_hi",    1, 1, 5'h0C, 32'hDEAD_BEEF, 32'h0,          0);
        vecs[3]  = mk("ld_cmp_hi",    1, 0, 5'h0C, 32'h0,         32'hDEAD_BEEF,  0);
        vecs[4]  = mk("ld_cmp_lo_b2b",1, 0, 5'h08, 32'h0,         32'h1234_5678,  0);
        vecs[5]  = mk("ld_cmp_lo_0b", 1, 0, 5'h0B, 32'h0,         32'h1234_5678,  0);
        vecs[6]  = mk("st_msip_ones", 1, 1, 5'h10, 32'hFFFF_FFFF, 32'h0,          1);
        vecs[7]  = mk("ld_msip_one",  1, 0, 5'h10, 32'h0,         32'h0000_0001,  1);
        vecs[8]  = mk("idle_hold",    0, 0, 5'h10, 32'h0,         32'h0,          1);
        vecs[9]  = mk("st_rsv_18",    1, 1, 5'h18, 32'h0000_1234, 32'h0,          1);
        vecs[10] = mk("ld_rsv_18",    1, 0, 5'h18, 32'h0,         32'h0,          1);
        vecs[11] = mk("st_rsv_1c",    1, 1, 5'h1C, 32'h0000_FFFF, 32'h0,          1);
        vecs[12] = mk("ld_rsv_1c",    1, 0, 5'h1C, 32'h0,         32'h0,          1);
        vecs[13] = mk("st_msip_11",   1, 1, 5'h11, 32'hFFFF_FFFE, 32'h0,          0);
        vecs[14] = mk("ld_msip_zero", 1, 0, 5'h10, 32'h0,         32'h0,          0);
        vecs[15] = mk("st_prescale7", 1, 1, 5'h14, 32'h0000_0007, 32'h0,          0);
        vecs[16] = mk("ld_prescale7", 1, 0, 5'h14, 32'h0,         NEW_PRESCALE_RB,0);
        vecs[17] = mk("st_prescale0", 1, 1, 5'h14, 32'h0,         32'h0,          0);
        vecs[18] = mk("ld_prescale0", 1, 0, 5'h14, 32'h0,         32'h0,          0);

        // Reset: hold 4 cycles, release on a falling edge.
        repeat (4) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("rst_mtip",   {31'd0, mtip_o},   32'd0);
        check("rst_msip",   {31'd0, msip_o},   32'd0);
        check("rst_rvalid", {31'd0, rvalid_o}, 32'd0);
        check("rst_rdata",  rdata_o,           32'd0);
        @(negedge clk);
        load_check("rst_cmp_hi",   5'h0C, 32'hFFFF_FFFF);
        load_check("rst_cmp_lo",   5'h08, 32'hFFFF_FFFF);
        load_check("rst_prescale", 5'h14, RST_PRESCALE_RB);

`ifdef CLINT_PRESCALE_EN
        // Divide by 4: 40 clocks give 10 ticks.
        store(5'h14, 32'd3);
        idle(40);
        load("tick_lo_rvalid", 5'h00, d);
        checks++;
        if (d < 32'd9 || d > 32'd11) begin
            failures++;
            $display("FAIL tick_lo: got %0d expected 9..11", d);
        end
        load_check("tick_hi", 5'h04, 32'd0);
        store(5'h14, 32'd0);
`else
        // Undivided: one tick per clock.
        store(5'h00, 32'd0);
        idle(40);
        load_check("tick_lo", 5'h00, 32'd40);
        load_check("tick_hi", 5'h04, 32'd0);
`endif

        // Register table.
        last_rd = 32'd0;
        for (int i = 0; i < NVEC; i++) begin
            req_i   = vecs[i].req;
            we_i    = vecs[i].we;
            addr_i  = vecs[i].addr;
            wdata_i = vecs[i].wdata;
            @(negedge clk);
            req_i = 1'b0;
            we_i  = 1'b0;
            exp_valid = vecs[i].req && !vecs[i].we;
            if (exp_valid) last_rd = vecs[i].exp_rdata;
            check({vecs[i].name, "_rvalid"}, {31'd0, rvalid_o}, {31'd0, exp_valid});
            check({vecs[i].name, "_rdata"},  rdata_o, last_rd);
            check({vecs[i].name, "_msip"},   {31'd0, msip_o}, {31'd0, vecs[i].exp_msip});
        end
        idle(1);
        check("after_table_rvalid", {31'd0, rvalid_o}, 32'd0);

        // Tear-free read across a lo->hi carry.
        store(5'h04, 32'd0);
        store(5'h00, 32'hFFFF_FFFE);
        load_check("tear_lo",  5'h00, 32'hFFFF_FFFE);
        load_check("tear_hi",  5'h04, 32'd0);
        idle(2);
        load_check("tear_hi_stale", 5'h04, 32'd0);
        load_check("tear_lo2", 5'h00, 32'd3);
        load_check("tear_hi2", 5'h04, 32'd1);

        // 64-bit wrap.
        store(5'h04, 32'hFFFF_FFFF);
        store(5'h00, 32'hFFFF_FFFF);
        load_check("wrap_lo_max", 5'h00, 32'hFFFF_FFFF);
        load_check("wrap_hi_max", 5'h04, 32'hFFFF_FFFF);
        load_check("wrap_lo_new", 5'h00, 32'd1);
        load_check("wrap_hi_new", 5'h04, 32'd0);

        // Timer interrupt: mtime = 0, mtimecmp = 5.
        store(5'h04, 32'd0);
        store(5'h00, 32'd0);
        store(5'h08, 32'd5);
        store(5'h0C, 32'd0);
        for (int k = 2; k <= 7; k++) begin
            check($sformatf("mtip_at_mtime_%0d", k), {31'd0, mtip_o}, (k >= 6) ? 32'd1 : 32'd0);
            @(negedge clk);
        end
        store(5'h08, 32'hFFFF_FFFF);
        check("mtip_store_edge", {31'd0, mtip_o}, 32'd1);
        @(negedge clk);
        check("mtip_fall", {31'd0, mtip_o}, 32'd0);

        // Store versus tick on the same edge.
        store(5'h00, 32'h0000_0100);
        load_check("coll_lo", 5'h00, 32'h0000_0100);
        store(5'h04, 32'd0);
        load_check("coll_hi_store_lo", 5'h00, 32'h0000_0101);

        // Reset while a load is in flight.
        store(5'h10, 32'd1);
        check("msip_pre_reset", {31'd0, msip_o}, 32'd1);
        req_i  = 1'b1;
        we_i   = 1'b0;
        addr_i = 5'h08;
        #2;
        rst_n = 1'b0;
        @(negedge clk);
        req_i = 1'b0;
        check("inflight_rvalid_in_reset", {31'd0, rvalid_o}, 32'd0);
        idle(2);
        rst_n = 1'b1;
        for (int k = 0; k < 3; k++) begin
            check($sformatf("inflight_rvalid_%0d", k), {31'd0, rvalid_o}, 32'd0);
            @(negedge clk);
        end
        check("inflight_rdata", rdata_o, 32'd0);
        check("inflight_msip", {31'd0, msip_o}, 32'd0);
        load_check("inflight_cmp_lo", 5'h08, 32'hFFFF_FFFF);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
